// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pipeline_stall_controller_if
// Description : Hazard/memory-status inputs and load/flush outputs of the
//               pipeline stall controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32,
    parameter int BUB_W = 16
);
    logic [4:0]       IF_ID_rs1_out;
    logic [4:0]       IF_ID_rs2_out;
    logic             IF_ID_uses_rs2;
    logic             ID_EX_memread;
    logic [4:0]       ID_EX_rd_out;
    logic             imem_read;
    logic             imem_resp;
    logic             dmem_access;
    logic             dmem_resp;
    logic             br_taken;

    logic             load_pc;
    logic             load_IF_ID;
    logic             load_ID_EX;
    logic             load_EX_MEM;
    logic             load_MEM_WB;
    logic             flush_IF_ID;
    logic             flush_ID_EX;
    logic [CNT_W-1:0] mem_stall_cycles;
    logic [BUB_W-1:0] bubble_count;

    // Pipeline side: supplies hazard and memory status, consumes enables.
    modport master (
        output IF_ID_rs1_out, IF_ID_rs2_out, IF_ID_uses_rs2,
        output ID_EX_memread, ID_EX_rd_out,
        output imem_read, imem_resp, dmem_access, dmem_resp, br_taken,
        input  load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
        input  flush_IF_ID, flush_ID_EX, mem_stall_cycles, bubble_count
    );

    // Controller side.
    modport slave (
        input  IF_ID_rs1_out, IF_ID_rs2_out, IF_ID_uses_rs2,
        input  ID_EX_memread, ID_EX_rd_out,
        input  imem_read, imem_resp, dmem_access, dmem_resp, br_taken,
        output load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
        output flush_IF_ID, flush_ID_EX, mem_stall_cycles, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pipeline_stall_controller
// Description : Freezes the pipeline on cache misses, inserts load-use bubbles,
//               flushes IF/ID and ID/EX on taken branches, counts stalls.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int CNT_W = 32,
    parameter int BUB_W = 16
) (
    input  wire                          clk,
    input  wire                          rst_n,
    pipeline_stall_controller_if.slave   bus
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [BUB_W-1:0] c_bub_one = BUB_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_imem_done;
    logic             r_dmem_done;
    logic             w_imem_done_nxt;
    logic             w_dmem_done_nxt;
    logic [CNT_W-1:0] r_mem_stall_cycles;
    logic [BUB_W-1:0] r_bubble_count;

    logic             w_imem_served;
    logic             w_dmem_served;
    logic             w_release;
    logic             w_load_use;
    logic             w_bubble;
    logic             w_load_pc;
    logic             w_load_if_id;
    logic             w_load_id_ex;
    logic             w_load_ex_mem;
    logic             w_load_mem_wb;
    logic             w_flush_if_id;
    logic             w_flush_id_ex;

    // A response pulse counts in its own cycle; a dropped request counts as served.
    assign w_imem_served = r_imem_done | bus.imem_resp;
    assign w_dmem_served = r_dmem_done | bus.dmem_resp;
    assign w_release     = (~bus.imem_read   | w_imem_served) &
                           (~bus.dmem_access | w_dmem_served);

    assign w_load_use = bus.ID_EX_memread && (bus.ID_EX_rd_out != 5'd0) &&
                        ((bus.ID_EX_rd_out == bus.IF_ID_rs1_out) ||
                         (bus.IF_ID_uses_rs2 && (bus.ID_EX_rd_out == bus.IF_ID_rs2_out)));

    always_comb begin
        w_state_nxt     = r_state;
        w_imem_done_nxt = r_imem_done;
        w_dmem_done_nxt = r_dmem_done;
        w_bubble        = 1'b0;
        w_load_pc       = 1'b0;
        w_load_if_id    = 1'b0;
        w_load_id_ex    = 1'b0;
        w_load_ex_mem   = 1'b0;
        w_load_mem_wb   = 1'b0;
        w_flush_if_id   = 1'b0;
        w_flush_id_ex   = 1'b0;

        if (w_release) begin
            w_state_nxt     = RUN;
            w_imem_done_nxt = 1'b0;
            w_dmem_done_nxt = 1'b0;
            if (bus.br_taken) begin
                // Branch wins over load-use: the consumer is flushed anyway.
                w_load_pc     = 1'b1;
                w_load_if_id  = 1'b1;
                w_load_id_ex  = 1'b1;
                w_load_ex_mem = 1'b1;
                w_load_mem_wb = 1'b1;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
            end else if (w_load_use) begin
                w_bubble      = 1'b1;
                w_load_id_ex  = 1'b1;
                w_load_ex_mem = 1'b1;
                w_load_mem_wb = 1'b1;
                w_flush_id_ex = 1'b1;
            end else begin
                w_load_pc     = 1'b1;
                w_load_if_id  = 1'b1;
                w_load_id_ex  = 1'b1;
                w_load_ex_mem = 1'b1;
                w_load_mem_wb = 1'b1;
            end
        end else begin
            w_imem_done_nxt = r_imem_done | bus.imem_resp;
            w_dmem_done_nxt = r_dmem_done | bus.dmem_resp;
            case (r_state)
                RUN:      w_state_nxt = MEM_WAIT;
                MEM_WAIT: w_state_nxt = MEM_WAIT;
                default:  w_state_nxt = RUN;
            endcase
        end

        // Nothing may load while reset is held.
        if (!rst_n) begin
            w_bubble      = 1'b0;
            w_load_pc     = 1'b0;
            w_load_if_id  = 1'b0;
            w_load_id_ex  = 1'b0;
            w_load_ex_mem = 1'b0;
            w_load_mem_wb = 1'b0;
            w_flush_if_id = 1'b0;
            w_flush_id_ex = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= RUN;
            r_imem_done        <= 1'b0;
            r_dmem_done        <= 1'b0;
            r_mem_stall_cycles <= '0;
            r_bubble_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_imem_done <= w_imem_done_nxt;
            r_dmem_done <= w_dmem_done_nxt;
            if (!w_release && (r_mem_stall_cycles != c_cnt_max))
                r_mem_stall_cycles <= r_mem_stall_cycles + c_cnt_one;
            if (w_bubble)
                r_bubble_count <= r_bubble_count + c_bub_one;
        end
    end

    assign bus.load_pc          = w_load_pc;
    assign bus.load_IF_ID       = w_load_if_id;
    assign bus.load_ID_EX       = w_load_id_ex;
    assign bus.load_EX_MEM      = w_load_ex_mem;
    assign bus.load_MEM_WB      = w_load_mem_wb;
    assign bus.flush_IF_ID      = w_flush_if_id;
    assign bus.flush_ID_EX      = w_flush_id_ex;
    assign bus.mem_stall_cycles = r_mem_stall_cycles;
    assign bus.bubble_count     = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_pipeline_stall_controller
// Description : Directed self-checking bench for pipeline_stall_controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    // Control vector {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB, flush_IF_ID, flush_ID_EX}
    localparam logic [31:0] c_frozen = 32'b00000_00;
    localparam logic [31:0] c_run    = 32'b11111_00;
    localparam logic [31:0] c_bubble = 32'b00111_01;
    localparam logic [31:0] c_flush  = 32'b11111_11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sat_rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(32), .BUB_W(16)) bus ();
    pipeline_stall_controller_if #(.CNT_W(3),  .BUB_W(16)) sat_bus ();

    pipeline_stall_controller #(.CNT_W(32), .BUB_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    pipeline_stall_controller #(.CNT_W(3), .BUB_W(16)) u_sat (
        .clk   (clk),
        .rst_n (sat_rst_n),
        .bus   (sat_bus.slave)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl();
        return {25'd0, bus.load_pc, bus.load_IF_ID, bus.load_ID_EX, bus.load_EX_MEM,
                bus.load_MEM_WB, bus.flush_IF_ID, bus.flush_ID_EX};
    endfunction

    function automatic logic [31:0] sat_ctrl();
        return {25'd0, sat_bus.load_pc, sat_bus.load_IF_ID, sat_bus.load_ID_EX, sat_bus.load_EX_MEM,
                sat_bus.load_MEM_WB, sat_bus.flush_IF_ID, sat_bus.flush_ID_EX};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.IF_ID_rs1_out  = 5'd0;
        bus.IF_ID_rs2_out  = 5'd0;
        bus.IF_ID_uses_rs2 = 1'b0;
        bus.ID_EX_memread  = 1'b0;
        bus.ID_EX_rd_out   = 5'd0;
        bus.imem_read      = 1'b0;
        bus.imem_resp      = 1'b0;
        bus.dmem_access    = 1'b0;
        bus.dmem_resp      = 1'b0;
        bus.br_taken       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_mem(input logic ir, input logic irsp, input logic da, input logic drsp);
        bus.imem_read   = ir;
        bus.imem_resp   = irsp;
        bus.dmem_access = da;
        bus.dmem_resp   = drsp;
    endtask

    task automatic set_hz(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u2, input logic br);
        bus.ID_EX_memread  = mr;
        bus.ID_EX_rd_out   = rd;
        bus.IF_ID_rs1_out  = rs1;
        bus.IF_ID_rs2_out  = rs2;
        bus.IF_ID_uses_rs2 = u2;
        bus.br_taken       = br;
    endtask

    initial begin
        idle_inputs();
        sat_bus.IF_ID_rs1_out  = 5'd0;
        sat_bus.IF_ID_rs2_out  = 5'd0;
        sat_bus.IF_ID_uses_rs2 = 1'b0;
        sat_bus.ID_EX_memread  = 1'b0;
        sat_bus.ID_EX_rd_out   = 5'd0;
        sat_bus.imem_read      = 1'b0;
        sat_bus.imem_resp      = 1'b0;
        sat_bus.dmem_access    = 1'b0;
        sat_bus.dmem_resp      = 1'b0;
        sat_bus.br_taken       = 1'b0;

        // Reset state
        #2;
        check_value("reset_ctrl", ctrl(), c_frozen);
        tick();
        rst_n = 1'b1;
        check_value("reset_stall_cnt", bus.mem_stall_cycles, 32'd0);
        check_value("reset_bub_cnt", 32'(bus.bubble_count), 32'd0);
        settle();
        check_value("idle_ctrl", ctrl(), c_run);
        tick();
        check_value("idle_stall_cnt", bus.mem_stall_cycles, 32'd0);

        // Load-use on rs1, then on rs2, then rd=0
        set_hz(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        settle();
        check_value("lu_rs1_ctrl", ctrl(), c_bubble);
        tick();
        check_value("lu_rs1_bub_cnt", 32'(bus.bubble_count), 32'd1);
        set_hz(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        settle();
        check_value("lu_after_ctrl", ctrl(), c_run);
        tick();
        set_hz(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0);
        settle();
        check_value("lu_rs2_ctrl", ctrl(), c_bubble);
        tick();
        check_value("lu_rs2_bub_cnt", 32'(bus.bubble_count), 32'd2);
        set_hz(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
        settle();
        check_value("lu_rs2_unused_ctrl", ctrl(), c_run);
        tick();
        set_hz(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        settle();
        check_value("lu_rd0_ctrl", ctrl(), c_run);
        tick();
        check_value("lu_rd0_bub_cnt", 32'(bus.bubble_count), 32'd2);

        // Branch plus load-use in the same cycle
        set_hz(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        settle();
        check_value("br_lu_ctrl", ctrl(), c_flush);
        tick();
        check_value("br_lu_bub_cnt", 32'(bus.bubble_count), 32'd2);

        // Split responses: dmem at cycle 2, imem at cycle 5
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_mem(1'b1, c == 5, 1'b1, c == 2);
            settle();
            check_value($sformatf("split_c%0d_ctrl", c), ctrl(), (c == 5) ? c_run : c_frozen);
            tick();
        end
        check_value("split_stall_cnt", bus.mem_stall_cycles, 32'd5);
        set_mem(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_value("split_after_ctrl", ctrl(), c_run);
        tick();

        // Simultaneous responses at cycle 3
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_mem(1'b1, c == 3, 1'b1, c == 3);
            settle();
            check_value($sformatf("simul_c%0d_ctrl", c), ctrl(), (c == 3) ? c_run : c_frozen);
            tick();
        end
        check_value("simul_stall_cnt", bus.mem_stall_cycles, 32'd3);

        // Branch held during a 4-cycle dmem stall
        do_reset();
        bus.br_taken = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_mem(1'b0, 1'b0, 1'b1, c == 4);
            settle();
            check_value($sformatf("br_stall_c%0d_ctrl", c), ctrl(), (c == 4) ? c_flush : c_frozen);
            tick();
        end
        check_value("br_stall_cnt", bus.mem_stall_cycles, 32'd4);

        // Dropped request counts as served
        do_reset();
        set_mem(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check_value("drop_c0_ctrl", ctrl(), c_frozen);
        tick();
        set_mem(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_value("drop_c1_ctrl", ctrl(), c_run);
        tick();

        // Reset mid-stall discards the sticky dmem flag
        do_reset();
        set_mem(1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        tick();
        set_mem(1'b1, 1'b0, 1'b1, 1'b1);
        settle();
        check_value("rst_mid_c1_ctrl", ctrl(), c_frozen);
        tick();
        set_mem(1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        settle();
        check_value("rst_mid_c2_ctrl", ctrl(), c_frozen);
        tick();
        rst_n = 1'b1;
        check_value("rst_mid_stall_cnt", bus.mem_stall_cycles, 32'd0);
        check_value("rst_mid_bub_cnt", 32'(bus.bubble_count), 32'd0);
        set_mem(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check_value("rst_mid_flag_lost_ctrl", ctrl(), c_frozen);
        tick();
        set_mem(1'b1, 1'b0, 1'b1, 1'b1);
        settle();
        check_value("rst_mid_reissue_ctrl", ctrl(), c_run);
        tick();
        check_value("rst_mid_reissue_cnt", bus.mem_stall_cycles, 32'd1);
        set_mem(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_value("rst_mid_idle_ctrl", ctrl(), c_run);
        tick();

        // Saturation on the 3-bit counter instance
        sat_rst_n = 1'b0;
        tick();
        sat_rst_n = 1'b1;
        sat_bus.dmem_access = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check_value("sat_cnt6", 32'(sat_bus.mem_stall_cycles), 32'd6);
        tick();
        check_value("sat_cnt7", 32'(sat_bus.mem_stall_cycles), 32'd7);
        tick();
        tick();
        tick();
        check_value("sat_hold", 32'(sat_bus.mem_stall_cycles), 32'd7);
        settle();
        check_value("sat_ctrl", sat_ctrl(), c_frozen);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RV32I pipeline. It freezes the pipeline while the instruction or data cache is busy and inserts one bubble for load-use hazards that operand forwarding cannot cover. It also flushes the IF/ID and ID/EX stages on a taken branch or jump resolved in EX, and keeps stall/bubble performance counters. Its outputs drive the load enables of the PC and of every pipeline register.

## Interface
Parameters:
- CNT_W, 32, width of `mem_stall_cycles` (saturating)
- BUB_W, 16, width of `bubble_count` (wrapping)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- IF_ID_rs1_out  in  5  rs1 of instruction in ID
- IF_ID_rs2_out  in  5  rs2 of instruction in ID
- IF_ID_uses_rs2  in  1  instruction in ID reads rs2 (reg, store, br)
- ID_EX_memread  in  1  instruction in EX is a load
- ID_EX_rd_out  in  5  rd of instruction in EX
- imem_read  in  1  IF has an instruction-cache request outstanding
- imem_resp  in  1  instruction-cache response, single-cycle pulse
- dmem_access  in  1  MEM stage holds a load or store
- dmem_resp  in  1  data-cache response, single-cycle pulse
- br_taken  in  1  EX resolved a taken branch or jump this cycle
- load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB  out  1 each  register load enables
- flush_IF_ID  out  1  clear IF/ID to a NOP on this edge
- flush_ID_EX  out  1  clear ID/EX control to zero on this edge (bubble)
- mem_stall_cycles  out  CNT_W  cycles spent frozen on memory
- bubble_count  out  BUB_W  load-use bubbles inserted

## Operation
State register `state` ∈ {RUN, MEM_WAIT}. It is accompanied by sticky flags `imem_done` and `dmem_done`.
- Served: the imem side is served when `imem_done | imem_resp`; the dmem side is served when `dmem_done | dmem_resp`.
- Release: `release = (~imem_read | imem served) & (~dmem_access | dmem served)`.
- RUN, release=0: all load_* = 0 and flush_* = 0.
  - Set `imem_done` if `imem_resp`; set `dmem_done` if `dmem_resp`.
  - Next state MEM_WAIT.
- MEM_WAIT, release=0: same as above. The flags stay sticky; the state stays MEM_WAIT.
- Either state, release=1: clear both flags and go to RUN. Outputs are chosen by this priority:
  1. `br_taken`: all load_* = 1; flush_IF_ID = flush_ID_EX = 1.
  2. Load-use: `ID_EX_memread & ID_EX_rd_out != 0 & (ID_EX_rd_out == IF_ID_rs1_out | (IF_ID_uses_rs2 & ID_EX_rd_out == IF_ID_rs2_out))`. Then load_pc = load_IF_ID = 0, flush_ID_EX = 1, and load_ID_EX = load_EX_MEM = load_MEM_WB = 1.
  3. Otherwise: all load_* = 1 and flush_* = 0.
- A memory stall has priority over `br_taken` and over load-use. A branch seen during a stall is acted on at the release cycle, because EX is frozen and `br_taken` stays asserted.
- Because `br_taken` has priority, a load-use condition in the same cycle is discarded: the consumer is flushed anyway.
- Counters, updated on the clock edge:
  - `mem_stall_cycles` increments on every cycle with release=0 and saturates at all-ones.
  - `bubble_count` increments on every priority-2 cycle and wraps modulo 2^BUB_W.

## Timing
- All enable and flush outputs are Mealy (combinational from state, flags and inputs), with zero-cycle latency. They are valid before the same rising edge that uses them.
- A response pulse is honoured on the cycle it arrives. If both sides are served in the same cycle, release occurs in that cycle.
- Reset: while rst_n = 0, all load_* = 0 and flush_* = 0. On the reset edge: state = RUN, both flags = 0, both counters = 0.
- Reset asserted mid-stall discards the sticky flags. The requesters must re-issue.
- A request whose `imem_read` or `dmem_access` drops before its response arrives counts as served.
- An idle pipeline (no requests, no hazards) gives all load_* = 1 on every cycle.
- A load-use bubble lasts exactly 1 cycle. On the next cycle the load is in MEM and the hazard term is false.

## Test plan
- Load-use: EX = load to x5 (ID_EX_memread=1, rd=5); ID reads rs1=5. Required response: load_pc=0, load_IF_ID=0, flush_ID_EX=1 for 1 cycle, and bubble_count 0→1. Repeat with rd=0: no bubble.
- Split responses: imem_read=dmem_access=1; dmem_resp pulses at cycle 2 and imem_resp at cycle 5. Required response: all load_* = 0 in cycles 0–4, load_* = 1 in cycle 5, mem_stall_cycles = 5, and no re-wait for dmem.
- Simultaneous responses: both resp pulse at cycle 3. Required response: release at cycle 3 and mem_stall_cycles = 3.
- Branch during stall: br_taken=1 held while dmem busy 4 cycles. Required response: flush_* = 0 while frozen, then flush_IF_ID = flush_ID_EX = 1 together with all load_* = 1 at the release cycle.
- Branch plus load-use in the same cycle: the flush wins, load_pc=1, and bubble_count is unchanged.
- Reset mid-stall: rst_n=0 at cycle 2 of a wait. Required response: outputs 0, counters 0, state RUN. After reset with no requests, all load_* = 1. Also preload mem_stall_cycles = 0xFFFFFFFF and stall: the counter holds at 0xFFFFFFFF.
